// File: rtl/mem_pipe_stage.sv
// EX->MEM pipeline stage: main register plus one-entry skid buffer, with load/store
// address-exception classification. Optional MEM_STAGE_BADVADDR_EN adds badvaddr_m capture.
module mem_pipe_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter logic [31:0] RAM_TOP     = 32'h0000_2fff,
  parameter logic [31:0] DEV0_BASE   = 32'h0000_7f00,
  parameter logic [31:0] DEV1_BASE   = 32'h0000_7f10,
  parameter int unsigned DEV_RD_SPAN = 12,
  parameter int unsigned DEV_WR_SPAN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       ir_e,
  input  logic [31:0]       pc_e,
  input  logic [DATA_W-1:0] alu_e,
  input  logic [DATA_W-1:0] md_e,
  input  logic [DATA_W-1:0] rt_e,
  input  logic              bd_e,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       ir_m,
  output logic [31:0]       pc_m,
  output logic [DATA_W-1:0] ao_m,
  output logic [DATA_W-1:0] mdo_m,
  output logic [DATA_W-1:0] rt_m,
  output logic              bd_m,
  output logic [4:0]        excode_m
`ifdef MEM_STAGE_BADVADDR_EN
  ,
  output logic [31:0]       badvaddr_m
`endif
);

  typedef struct packed {
    logic [31:0]       ir;
    logic [31:0]       pc;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] md;
    logic [DATA_W-1:0] rt;
    logic              bd;
  } bundle_t;

  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
                         OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;

  localparam logic [31:0] DEV0_RD_LAST = DEV0_BASE + 32'(DEV_RD_SPAN) - 32'd1;
  localparam logic [31:0] DEV1_RD_LAST = DEV1_BASE + 32'(DEV_RD_SPAN) - 32'd1;
  localparam logic [31:0] DEV0_WR_LAST = DEV0_BASE + 32'(DEV_WR_SPAN) - 32'd1;
  localparam logic [31:0] DEV1_WR_LAST = DEV1_BASE + 32'(DEV_WR_SPAN) - 32'd1;

  bundle_t r_m, r_s;
  logic    r_m_valid, r_s_valid;
  bundle_t w_in;
  logic    w_in_fire, w_out_fire;

  assign w_in       = '{ir: ir_e, pc: pc_e, alu: alu_e, md: md_e, rt: rt_e, bd: bd_e};
  assign w_in_fire  = in_valid && !r_s_valid;
  assign w_out_fire = r_m_valid && out_ready;

  // in_ready is just the registered complement of the skid valid bit, so no out_ready path.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m       <= '0;
      r_s       <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (!r_m_valid || w_out_fire) begin
      if (r_s_valid) begin
        r_m       <= r_s;
        r_m_valid <= 1'b1;
        r_s_valid <= w_in_fire;
        if (w_in_fire) r_s <= w_in;
      end else begin
        r_m_valid <= w_in_fire;
        if (w_in_fire) r_m <= w_in;
        r_s_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_s       <= w_in;
      r_s_valid <= 1'b1;
    end
  end

  assign in_ready  = !r_s_valid;
  assign out_valid = r_m_valid;
  assign ir_m      = r_m.ir;
  assign pc_m      = r_m.pc;
  assign ao_m      = r_m.alu;
  assign mdo_m     = r_m.md;
  assign rt_m      = r_m.rt;
  assign bd_m      = r_m.bd;

  // Address decode assumes DATA_W >= 32; the low 32 bits form the byte address.
  logic [31:0] w_addr;
  logic [5:0]  w_op;
  logic        w_is_load, w_is_store, w_word, w_half, w_sub_word;
  logic        w_in_ram, w_in_dev_rd, w_in_dev_wr, w_misalign;

  assign w_addr      = r_m.alu[31:0];
  assign w_op        = r_m.ir[31:26];
  assign w_is_load   = (w_op == OP_LW) || (w_op == OP_LB) || (w_op == OP_LBU) ||
                       (w_op == OP_LH) || (w_op == OP_LHU);
  assign w_is_store  = (w_op == OP_SW) || (w_op == OP_SB) || (w_op == OP_SH);
  assign w_word      = (w_op == OP_LW) || (w_op == OP_SW);
  assign w_half      = (w_op == OP_LH) || (w_op == OP_LHU) || (w_op == OP_SH);
  assign w_sub_word  = !w_word;
  assign w_in_ram    = (w_addr <= RAM_TOP);
  assign w_in_dev_rd = ((w_addr >= DEV0_BASE) && (w_addr <= DEV0_RD_LAST)) ||
                       ((w_addr >= DEV1_BASE) && (w_addr <= DEV1_RD_LAST));
  assign w_in_dev_wr = ((w_addr >= DEV0_BASE) && (w_addr <= DEV0_WR_LAST)) ||
                       ((w_addr >= DEV1_BASE) && (w_addr <= DEV1_WR_LAST));
  assign w_misalign  = (w_word && (w_addr[1:0] != 2'b00)) || (w_half && w_addr[0]);

  always_comb begin
    excode_m = '0;
    if (r_m_valid) begin
      if (w_is_load &&
          (w_misalign || !(w_in_ram || w_in_dev_rd) || (w_sub_word && w_in_dev_rd)))
        excode_m = 5'd4;
      else if (w_is_store &&
               (w_misalign || !(w_in_ram || w_in_dev_wr) || (w_sub_word && w_in_dev_wr)))
        excode_m = 5'd5;
    end
  end

`ifdef MEM_STAGE_BADVADDR_EN
  logic r_badv_set;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      badvaddr_m <= '0;
      r_badv_set <= 1'b0;
    end else if ((excode_m != 5'd0) && !r_badv_set) begin
      badvaddr_m <= w_addr;
      r_badv_set <= 1'b1;
    end
  end
`endif

endmodule
